// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the CPU datapath.
// Drives the datapath control strobes directly from the T-state register.
// The opcode field of IR selects the execute path. Datapath strobes that this
// sequencer never uses (HIin/out, LOin/out, Yout, Zhighout, MARout, Inport,
// CONin) are tied low where the datapath is assembled.
//
// state | meaning
// ------+----------------------------------------------------------------
// RST   | reset cycle; all strobes low, Run high
// T0    | PC -> MAR, Z <- PC+1
// T1    | PC <- Z, MDR <- mem[MAR]
// T2    | IR <- MDR
// T3    | decode IR; first execute step (or nop/halt dispatch)
// T4    | ALU step (Y op C or Y op Rc)
// T5    | Z to bus: address to MAR (ld/st) or result to Ra
// T6    | memory read (ld) or Ra -> MDR (st)
// T7    | MDR -> Ra (ld) or memory write (st)
// HALT  | stopped; Run low until reset

`timescale 1ns/1ps

module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        Run,
  output logic [4:0]  opcode,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_LD   = 3'd1,
    C_LDI  = 3'd2,
    C_ST   = 3'd3,
    C_ALU  = 3'd4,
    C_ALUI = 3'd5,
    C_HALT = 3'd6
  } class_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_e     state_q;
  state_e     state_d;
  class_e     ir_class;
  logic [4:0] ir_op;
  logic [4:0] alu_sel;
  logic       unused_ir;

  assign ir_op = IR[31:27];

  // Register, constant and shift fields are consumed by the datapath, not here.
  assign unused_ir = ^IR[26:0];

  // Classify the current IR opcode and pick the ALU operation for the T4 step.
  always_comb begin
    ir_class = C_NOP;
    alu_sel  = OP_ADD;
    unique case (ir_op)
      OP_LD:   ir_class = C_LD;
      OP_LDI:  ir_class = C_LDI;
      OP_ST:   ir_class = C_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        ir_class = C_ALU;
        alu_sel  = ir_op;
      end
      OP_ADDI: begin
        ir_class = C_ALUI;
        alu_sel  = OP_ADD;
      end
      OP_ANDI: begin
        ir_class = C_ALUI;
        alu_sel  = OP_AND;
      end
      OP_ORI: begin
        ir_class = C_ALUI;
        alu_sel  = OP_OR;
      end
      OP_HALT: ir_class = C_HALT;
      OP_NOP:  ir_class = C_NOP;
      default: ir_class = C_NOP;
    endcase
  end

  // State register; clear forces RST at once, aborting any instruction.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed fetch walk, then the execute length depends on the class.
  always_comb begin
    state_d = S_RST;
    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        if (ir_class == C_HALT) begin
          state_d = S_HALT;
        end else if (ir_class == C_NOP) begin
          state_d = S_T0;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:  state_d = S_T5;
      S_T5: begin
        if ((ir_class == C_LD) || (ir_class == C_ST)) begin
          state_d = S_T6;
        end else begin
          state_d = S_T0;
        end
      end
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Output decode: every strobe is low unless this state names it.
  always_comb begin
    Run     = (state_q != S_HALT);
    opcode  = 5'b00000;
    Read    = 1'b0;
    Write   = 1'b0;
    IncPC   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IRin    = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        // Address forms use BAout so that Rb = R0 yields an absolute address.
        if ((ir_class == C_LD) || (ir_class == C_LDI) || (ir_class == C_ST)) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if ((ir_class == C_ALU) || (ir_class == C_ALUI)) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        if (ir_class == C_ALU) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          opcode = alu_sel;
        end else begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          opcode = alu_sel;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if ((ir_class == C_LD) || (ir_class == C_ST)) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        if (ir_class == C_LD) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (ir_class == C_ST) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (ir_class == C_LD) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (ir_class == C_ST) begin
          Write = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions followed by random opcodes,
// each step compared against a per-instruction step table.
`timescale 1ns/1ps

module tb_control_unit;

  logic        Clock;
  logic        clear;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  opcode;
  logic        Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCout, PCin, IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Cout;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Run(Run), .opcode(opcode),
    .Read(Read), .Write(Write), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .PCout(PCout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Observed bundle: {Run, opcode, Read, Write, IncPC, Gra, Grb, Grc, Rin,
  // Rout, BAout, PCout, PCin, IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Cout}
  logic [24:0] obs;
  assign obs = {Run, opcode, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
                PCout, PCin, IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Cout};

  localparam logic [24:0] COUT = 25'd1 << 0;
  localparam logic [24:0] ZLO  = 25'd1 << 1;
  localparam logic [24:0] ZIN  = 25'd1 << 2;
  localparam logic [24:0] YIN  = 25'd1 << 3;
  localparam logic [24:0] MDRO = 25'd1 << 4;
  localparam logic [24:0] MDRI = 25'd1 << 5;
  localparam logic [24:0] MARI = 25'd1 << 6;
  localparam logic [24:0] IRI  = 25'd1 << 7;
  localparam logic [24:0] PCI  = 25'd1 << 8;
  localparam logic [24:0] PCO  = 25'd1 << 9;
  localparam logic [24:0] BAO  = 25'd1 << 10;
  localparam logic [24:0] RO   = 25'd1 << 11;
  localparam logic [24:0] RI   = 25'd1 << 12;
  localparam logic [24:0] GRC  = 25'd1 << 13;
  localparam logic [24:0] GRB  = 25'd1 << 14;
  localparam logic [24:0] GRA  = 25'd1 << 15;
  localparam logic [24:0] INC  = 25'd1 << 16;
  localparam logic [24:0] WR   = 25'd1 << 17;
  localparam logic [24:0] RD   = 25'd1 << 18;
  localparam logic [24:0] RUN  = 25'd1 << 24;
  localparam logic [24:0] BUS  = PCO | ZLO | MDRO | RO | BAO | COUT;

  localparam int K_NOP = 0, K_LD = 1, K_LDI = 2, K_ST = 3, K_ALU = 4, K_ALUI = 5, K_HALT = 6;

  function automatic logic [24:0] opf(input logic [4:0] o);
    return {o, 19'd0};
  endfunction

  function automatic int kind_of(input logic [4:0] op);
    case (op)
      5'd0:  return K_LD;
      5'd1:  return K_LDI;
      5'd2:  return K_ST;
      5'd3, 5'd4, 5'd9, 5'd10: return K_ALU;
      5'd11, 5'd12, 5'd13: return K_ALUI;
      5'd26: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  // Total cycles for the instruction (for halt: cycles before HALT).
  function automatic int instr_len(input logic [4:0] op);
    case (kind_of(op))
      K_LD, K_ST: return 8;
      K_LDI, K_ALU, K_ALUI: return 6;
      default: return 4;
    endcase
  endfunction

  // Expected bundle for step k (0 = T0) of an instruction with opcode op.
  function automatic logic [24:0] model(input logic [4:0] op, input int k);
    logic [24:0] fetch [3];
    logic [24:0] ex [5];
    logic [4:0]  imm_op;
    int          kd;
    fetch[0] = PCO | MARI | INC | ZIN;
    fetch[1] = ZLO | PCI | RD | MDRI;
    fetch[2] = MDRO | IRI;
    for (int i = 0; i < 5; i++) ex[i] = '0;
    kd = kind_of(op);
    imm_op = (op == 5'd12) ? 5'd9 : (op == 5'd13) ? 5'd10 : 5'd3;
    case (kd)
      K_LD: begin
        ex[0] = GRB | BAO | YIN; ex[1] = COUT | ZIN | opf(5'd3);
        ex[2] = ZLO | MARI; ex[3] = RD | MDRI; ex[4] = MDRO | GRA | RI;
      end
      K_LDI: begin
        ex[0] = GRB | BAO | YIN; ex[1] = COUT | ZIN | opf(5'd3);
        ex[2] = ZLO | GRA | RI;
      end
      K_ST: begin
        ex[0] = GRB | BAO | YIN; ex[1] = COUT | ZIN | opf(5'd3);
        ex[2] = ZLO | MARI; ex[3] = GRA | RO | MDRI; ex[4] = WR;
      end
      K_ALU: begin
        ex[0] = GRB | RO | YIN; ex[1] = GRC | RO | ZIN | opf(op);
        ex[2] = ZLO | GRA | RI;
      end
      K_ALUI: begin
        ex[0] = GRB | RO | YIN; ex[1] = COUT | ZIN | opf(imm_op);
        ex[2] = ZLO | GRA | RI;
      end
      default: begin
      end
    endcase
    if (k < 3) return RUN | fetch[k];
    return RUN | ex[k - 3];
  endfunction

  task automatic check(input string tag, input logic [24:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %07h expected %07h", tag, obs, exp);
    end
    n_checks++;
    assert ($countones(obs & BUS) <= 1) else begin
      n_fail++;
      $error("FAIL %s bus-exclusive: observed drivers %07h expected at most one", tag, obs & BUS);
    end
  endtask

  // Assert clear between edges, hold it over one edge, release just after an
  // edge so the next full cycle is RST and the edge after that enters T0.
  task automatic async_reset(input string tag);
    #1;
    clear = 1'b0;
    #1;
    check({tag, " async-rst"}, RUN);
    @(posedge Clock);
    #1;
    check({tag, " held-rst"}, RUN);
    clear = 1'b1;
    #1;
    check({tag, " rst-state"}, RUN);
  endtask

  // Run one instruction from T0. IR is loaded by the edge that ends T2.
  task automatic run_instr(input logic [31:0] word, input int abort_k,
                           input int halt_cycles, input string name);
    int len;
    len = instr_len(word[31:27]);
    for (int k = 0; k < len; k++) begin
      @(posedge Clock);
      #1;
      if (k == 3) IR = word;
      #1;
      check($sformatf("%s T%0d", name, k), model(word[31:27], k));
      if (k == abort_k) begin
        async_reset($sformatf("%s abort@T%0d", name, k));
        return;
      end
    end
    if (kind_of(word[31:27]) == K_HALT) begin
      for (int i = 0; i < halt_cycles; i++) begin
        @(posedge Clock);
        #2;
        check($sformatf("%s HALT c%0d", name, i), '0);
      end
      async_reset({name, " exit-halt"});
    end
  endtask

  logic [4:0] known_ops [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10,
                                 5'd11, 5'd12, 5'd13, 5'd25, 5'd26};

  initial begin
    logic [4:0]  op;
    logic [31:0] word;
    int          ab;
    clear = 1'b0;
    IR    = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset", RUN);
    clear = 1'b1;
    #1;
    check("reset-release", RUN);

    run_instr(32'h0080005F, -1, 0, "ld");
    run_instr(32'h18910000, -1, 0, "add");
    run_instr(32'h10800010, -1, 0, "st");
    run_instr(32'h6088000F, -1, 0, "andi");
    run_instr(32'h08800064, -1, 0, "ldi");
    run_instr(32'h21910000, -1, 0, "sub");
    run_instr(32'h49910000, -1, 0, "and");
    run_instr(32'h51910000, -1, 0, "or");
    run_instr(32'h58880007, -1, 0, "addi");
    run_instr(32'h68880003, -1, 0, "ori");
    run_instr(32'hC8000000, -1, 0, "nop");
    run_instr(32'hD0000000, -1, 20, "halt");
    run_instr(32'hF8000000, -1, 0, "unknown");
    run_instr(32'h0080005F, 4, 0, "ld-abort");
    run_instr(32'h08800001, -1, 0, "ldi-after-abort");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else op = known_ops[$urandom_range(0, 11)];
      word = {op, 27'($urandom)};
      ab = -1;
      if ($urandom_range(0, 5) == 0) ab = $urandom_range(0, instr_len(op) - 1);
      run_instr(word, ab, 3, $sformatf("rnd%0d op%05b", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
